video_compositor: RTL



---
 rtl/video_pkg.sv | 55 +++++
 rtl/pipe_delay.sv | 32 +++
 rtl/video_compositor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the 720p video compositor.
package video_pkg;

    // Active-area geometry of the 720p raster and the derived counter widths
    localparam int H_ACTIVE  = 1280;
    localparam int V_ACTIVE  = 720;
    localparam int H_BITS    = $clog2(H_ACTIVE);
    localparam int V_BITS    = $clog2(V_ACTIVE);
    localparam int BAR_W     = 160;
    localparam int LEVEL_MAX = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        MODE_WINDOW = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_RAMP   = 2'd2,
        MODE_BLACK  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        FADE_STEADY = 2'd0,
        FADE_OUT    = 2'd1,
        FADE_IN     = 2'd2
    } fade_state_t;

    // Classic eight-bar pattern; anything past the last bar is black
    function automatic rgb_t barColor(input logic [H_BITS-1:0] x);
        rgb_t c;
        int   xi;
        xi = int'(x);
        if      (xi < 1 * BAR_W) c = '{8'hFF, 8'hFF, 8'hFF};
        else if (xi < 2 * BAR_W) c = '{8'hFF, 8'hFF, 8'h00};
        else if (xi < 3 * BAR_W) c = '{8'h00, 8'hFF, 8'hFF};
        else if (xi < 4 * BAR_W) c = '{8'h00, 8'hFF, 8'h00};
        else if (xi < 5 * BAR_W) c = '{8'hFF, 8'h00, 8'hFF};
        else if (xi < 6 * BAR_W) c = '{8'hFF, 8'h00, 8'h00};
        else if (xi < 7 * BAR_W) c = '{8'h00, 8'h00, 8'hFF};
        else                     c = '{8'h00, 8'h00, 8'h00};
        return c;
    endfunction

    // Brightness scaling: level 16 is unity gain, level 0 is black
    function automatic logic [7:0] fadeScale(input logic [7:0] c, input logic [4:0] level);
        logic [12:0] prod;
        prod = 13'(c) * 13'(level);
        prod = prod >> 4;
        return prod[7:0];
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Synchronous-reset shift register; DEPTH = 0 degenerates to a wire.
module pipe_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_shift
            logic [W-1:0] stage_q [DEPTH];

            // Shift the input down the chain one stage per clock, clearing every stage on reset
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_compositor.sv
// Composites the renderer window, border and background (or a full-screen
// test pattern) onto the 720p raster, with a frame-stepped fade between modes.
// Optional build macro VIDEO_COMPOSITOR_CROSSHAIR_EN inverts the window's
// centre row and column to give an alignment crosshair.
module video_compositor
    import video_pkg::*;
#(
    parameter int          WIDTH        = 300,
    parameter int          HEIGHT       = 300,
    parameter int          X0           = 490,
    parameter int          Y0           = 210,
    parameter int          BORDER       = 4,
    parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR     = 24'h202020,
    parameter int          RENDER_LAT   = 2
) (
    input  logic              clk_pixel_in,
    input  logic              rst_in,
    input  logic [H_BITS-1:0] hcount_in,
    input  logic [V_BITS-1:0] vcount_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              ad_in,
    input  logic              nf_in,
    input  logic [7:0]        red_in,
    input  logic [7:0]        green_in,
    input  logic [7:0]        blue_in,
    input  logic [1:0]        mode_in,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic              ad_out,
    output logic              fade_busy_out
);

    localparam int TW = H_BITS + V_BITS + 3;

    logic [TW-1:0]     timingIn;
    logic [TW-1:0]     timingAl;
    logic [H_BITS-1:0] alX;
    logic [V_BITS-1:0] alY;
    logic              alHs;
    logic              alVs;
    logic              alAd;
    rgb_t              rendPix;
    mode_t             reqMode;

    fade_state_t       state_q, state_d;
    logic [4:0]        level_q, level_d;
    mode_t             activeMode_q, activeMode_d;
    logic              fadeBusy_q;

    int                xi;
    int                yi;
    logic              inWin;
    logic              inFrame;
    rgb_t              pix1_d;
    rgb_t              pix1_q;
    logic              hs1_q, vs1_q, ad1_q;
    rgb_t              out_q;
    logic              hsOut_q, vsOut_q, adOut_q;

    assign timingIn = {hcount_in, vcount_in, hs_in, vs_in, ad_in};
    assign rendPix  = '{red_in, green_in, blue_in};
    assign reqMode  = mode_t'(mode_in);

    pipe_delay #(
        .W     (TW),
        .DEPTH (RENDER_LAT)
    ) u_align (
        .clk_i (clk_pixel_in),
        .rst_i (rst_in),
        .d_i   (timingIn),
        .q_o   (timingAl)
    );

    assign {alX, alY, alHs, alVs, alAd} = timingAl;

    // Fade controller: only acts on new-frame pulses, stepping brightness and swapping mode at black
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        activeMode_d = activeMode_q;
        if (nf_in) begin
            case (state_q)
                FADE_STEADY: begin
                    if (reqMode != activeMode_q) begin
                        state_d = FADE_OUT;
                        level_d = level_q - 5'd1;
                    end
                end
                FADE_OUT: begin
                    if (reqMode == activeMode_q) begin
                        state_d = FADE_IN;
                        level_d = level_q + 5'd1;
                    end else if (level_q <= 5'd1) begin
                        // Level 0 can be reached here after a reversal from low FADE_IN levels
                        level_d      = 5'd0;
                        activeMode_d = reqMode;
                        state_d      = FADE_IN;
                    end else begin
                        level_d = level_q - 5'd1;
                    end
                end
                FADE_IN: begin
                    if (reqMode != activeMode_q) begin
                        if (level_q == 5'd0) begin
                            // Already black, so swap straight away instead of wrapping the level
                            activeMode_d = reqMode;
                        end else begin
                            state_d = FADE_OUT;
                            level_d = level_q - 5'd1;
                        end
                    end else if (level_q == 5'(LEVEL_MAX - 1)) begin
                        level_d = 5'(LEVEL_MAX);
                        state_d = FADE_STEADY;
                    end else begin
                        level_d = level_q + 5'd1;
                    end
                end
                default: begin
                    state_d = FADE_STEADY;
                    level_d = 5'(LEVEL_MAX);
                end
            endcase
        end
    end

    // Fade state registers; busy flag tracks the next state so it lines up with state_q
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_q      <= FADE_STEADY;
            level_q      <= 5'(LEVEL_MAX);
            activeMode_q <= MODE_WINDOW;
            fadeBusy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            activeMode_q <= activeMode_d;
            fadeBusy_q   <= (state_d != FADE_STEADY);
        end
    end

    // Classify the aligned pixel position and pick the source colour for the active mode
    always_comb begin
        xi      = int'(alX);
        yi      = int'(alY);
        inWin   = (xi >= X0) && (xi < X0 + WIDTH) && (yi >= Y0) && (yi < Y0 + HEIGHT);
        inFrame = (xi >= X0 - BORDER) && (xi < X0 + WIDTH + BORDER) &&
                  (yi >= Y0 - BORDER) && (yi < Y0 + HEIGHT + BORDER);
        pix1_d  = '0;
        if (alAd) begin
            case (activeMode_q)
                MODE_WINDOW: begin
                    if (inWin) begin
                        pix1_d = rendPix;
`ifdef VIDEO_COMPOSITOR_CROSSHAIR_EN
                        if ((xi == X0 + WIDTH / 2) || (yi == Y0 + HEIGHT / 2)) begin
                            pix1_d = rgb_t'(~rendPix);
                        end
`endif
                    end else if (inFrame) begin
                        pix1_d = rgb_t'(BORDER_COLOR);
                    end else begin
                        pix1_d = rgb_t'(BG_COLOR);
                    end
                end
                MODE_BARS: pix1_d = barColor(alX);
                MODE_RAMP: pix1_d = '{alX[7:0], alX[7:0], alX[7:0]};
                default:   pix1_d = '0;
            endcase
        end
    end

    // Stage 1: register the selected colour alongside the aligned sync signals
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            pix1_q <= '0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            ad1_q  <= 1'b0;
        end else begin
            pix1_q <= pix1_d;
            hs1_q  <= alHs;
            vs1_q  <= alVs;
            ad1_q  <= alAd;
        end
    end

    // Stage 2: apply the fade level to each channel and carry sync along
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            out_q   <= '0;
            hsOut_q <= 1'b0;
            vsOut_q <= 1'b0;
            adOut_q <= 1'b0;
        end else begin
            out_q.r <= fadeScale(pix1_q.r, level_q);
            out_q.g <= fadeScale(pix1_q.g, level_q);
            out_q.b <= fadeScale(pix1_q.b, level_q);
            hsOut_q <= hs1_q;
            vsOut_q <= vs1_q;
            adOut_q <= ad1_q;
        end
    end

    assign red_out       = out_q.r;
    assign green_out     = out_q.g;
    assign blue_out      = out_q.b;
    assign hs_out        = hsOut_q;
    assign vs_out        = vsOut_q;
    assign ad_out        = adOut_q;
    assign fade_busy_out = fadeBusy_q;

endmodule
